// File: rtl/regfile_dec4.sv
// 4-entry register file: one-hot decoded write port, two combinational read
// ports, optional write-to-read bypass and optional hardwired zero register.

module regfile_dec4_cell #(
  parameter int WIDTH   = 32,
  parameter bit RST_VLD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);
  // vld is sticky: only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      vld <= RST_VLD;
    end else if (ld) begin
      q   <= d;
      vld <= 1'b1;
    end
  end
endmodule

module regfile_dec4_rdport #(
  parameter int WIDTH    = 32,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [1:0]            raddr,
  input  logic [3:0]            wdec,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [3:0][WIDTH-1:0] regs,
  output logic [WIDTH-1:0]      rdata
);
  // zero register outranks bypass; wdec[0] is already masked in that case
  always_comb begin
    rdata = regs[raddr];
    if (BYPASS != 0 && wdec[raddr]) rdata = wdata;
    if (ZERO_REG != 0 && raddr == 2'd0) rdata = '0;
  end
endmodule

module regfile_dec4 #(
  parameter int WIDTH    = 32,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       raddr_a,
  input  logic [1:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic [3:0]       wdec,
  output logic [3:0]       valid
);
  localparam int NUM_REGS  = 4;
  localparam int NUM_PORTS = 2;

  logic [NUM_REGS-1:0]             dec;
  logic [NUM_REGS-1:0][WIDTH-1:0]  regs;
  logic [NUM_PORTS-1:0][1:0]       raddr;
  logic [NUM_PORTS-1:0][WIDTH-1:0] rdata;

  always_comb begin
    dec = we ? (4'b0001 << waddr) : 4'b0000;
    if (ZERO_REG != 0) dec[0] = 1'b0;
  end

  assign wdec = dec;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    regfile_dec4_cell #(
      .WIDTH  (WIDTH),
      .RST_VLD(g == 0 && ZERO_REG != 0)
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .ld (dec[g]),
      .d  (wdata),
      .q  (regs[g]),
      .vld(valid[g])
    );
  end

  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    regfile_dec4_rdport #(
      .WIDTH   (WIDTH),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .raddr(raddr[p]),
      .wdec (dec),
      .wdata(wdata),
      .regs (regs),
      .rdata(rdata[p])
    );
  end

  assign rdata_a = rdata[0];
  assign rdata_b = rdata[1];
endmodule

// File: tb/tb_regfile_dec4.sv
// Bench for regfile_dec4: default build (bypass + zero reg) and a plain build
// (neither) driven in parallel and compared against an array-based model.

module tb_regfile_dec4;
  logic        clk = 1'b0;
  logic        rst, we;
  logic [1:0]  waddr, raddr_a, raddr_b;
  logic [31:0] wdata;

  logic [31:0] d0_rda, d0_rdb, d1_rda, d1_rdb;
  logic [3:0]  d0_wdec, d0_valid, d1_wdec, d1_valid;

  int n_chk  = 0;
  int n_pass = 0;

  // model state: index 0 = default build, index 1 = plain build
  logic [31:0] mreg [2][4];
  logic [3:0]  mvld [2];

  always #5 clk = ~clk;

  regfile_dec4 u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(d0_rda), .rdata_b(d0_rdb), .wdec(d0_wdec), .valid(d0_valid)
  );

  regfile_dec4 #(.WIDTH(32), .BYPASS(0), .ZERO_REG(0)) u_alt (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(d1_rda), .rdata_b(d1_rdb), .wdec(d1_wdec), .valid(d1_valid)
  );

  function automatic bit has_zero(int c); return c == 0; endfunction
  function automatic bit has_byp(int c);  return c == 0; endfunction

  // index of the register a write lands in this cycle, or -1 if none
  function automatic int wr_target(int c);
    if (!we) return -1;
    if (has_zero(c) && waddr == 2'd0) return -1;
    return int'(waddr);
  endfunction

  function automatic logic [3:0] exp_wdec(int c);
    logic [3:0] r;
    int t;
    r = 4'b0000;
    t = wr_target(c);
    if (t >= 0) r[t] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(int c, logic [1:0] a);
    if (has_zero(c) && a == 2'd0) return 32'h0;
    if (has_byp(c) && wr_target(c) == int'(a)) return wdata;
    return mreg[c][a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] wa,
                       input logic [31:0] wd, input logic [1:0] ra, input logic [1:0] rb);
    rst = r; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
  endtask

  // let inputs settle, then compare every output of both builds to the model
  task automatic settle();
    #3;
    check("d0_wdec",  {28'h0, d0_wdec},  {28'h0, exp_wdec(0)});
    check("d0_rda",   d0_rda,            exp_rd(0, raddr_a));
    check("d0_rdb",   d0_rdb,            exp_rd(0, raddr_b));
    check("d0_valid", {28'h0, d0_valid}, {28'h0, mvld[0]});
    check("d1_wdec",  {28'h0, d1_wdec},  {28'h0, exp_wdec(1)});
    check("d1_rda",   d1_rda,            exp_rd(1, raddr_a));
    check("d1_rdb",   d1_rdb,            exp_rd(1, raddr_b));
    check("d1_valid", {28'h0, d1_valid}, {28'h0, mvld[1]});
  endtask

  task automatic edge_update();
    int t;
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) mreg[c][i] = 32'h0;
        mvld[c] = has_zero(c) ? 4'b0001 : 4'b0000;
      end else begin
        t = wr_target(c);
        if (t >= 0) begin
          mreg[c][t] = wdata;
          mvld[c][t] = 1'b1;
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [3:0] sweep_exp [4];
    sweep_exp[0] = 4'b0000; sweep_exp[1] = 4'b0010;
    sweep_exp[2] = 4'b0100; sweep_exp[3] = 4'b1000;

    // reset held 2 cycles against a competing write; first cycle unchecked
    drive(1, 1, 2'd2, 32'hDEAD_BEEF, 2'd2, 2'd0);
    edge_update();
    settle();
    check("rst_bypass_a", d0_rda, 32'hDEAD_BEEF);
    edge_update();

    drive(0, 0, 2'd0, 32'h0, 2'd2, 2'd1);
    settle();
    check("rst_valid0", {28'h0, d0_valid}, 32'h1);
    check("rst_valid1", {28'h0, d1_valid}, 32'h0);
    check("rst_reg2",   d0_rda, 32'h0);
    edge_update();

    drive(0, 1, 2'd1, 32'h1111_1111, 2'd0, 2'd0); settle(); edge_update();
    drive(0, 1, 2'd3, 32'h3333_3333, 2'd0, 2'd0); settle(); edge_update();
    drive(0, 0, 2'd0, 32'h0, 2'd1, 2'd3);
    settle();
    check("wr_rda",   d0_rda, 32'h1111_1111);
    check("wr_rdb",   d0_rdb, 32'h3333_3333);
    check("wr_valid", {28'h0, d0_valid}, 32'hB);
    edge_update();

    drive(0, 1, 2'd2, 32'hA5A5_A5A5, 2'd2, 2'd2);
    settle();
    check("byp_on",  d0_rda, 32'hA5A5_A5A5);
    check("byp_off", d1_rda, 32'h0);
    edge_update();
    drive(0, 0, 2'd0, 32'h0, 2'd2, 2'd2);
    settle();
    check("byp_off_after", d1_rda, 32'hA5A5_A5A5);
    edge_update();

    drive(0, 1, 2'd0, 32'hFFFF_FFFF, 2'd0, 2'd0);
    settle();
    check("zero_wdec", {28'h0, d0_wdec}, 32'h0);
    edge_update();
    drive(0, 0, 2'd0, 32'h0, 2'd0, 2'd0);
    settle();
    check("zero_rd",   d0_rda, 32'h0);
    check("nozero_rd", d1_rda, 32'hFFFF_FFFF);
    check("nozero_v0", {31'h0, d1_valid[0]}, 32'h1);
    edge_update();

    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 2'(i), 32'hC000_0000 + 32'(i), 2'(i), 2'(3 - i));
      settle();
      check("sweep_wdec", {28'h0, d0_wdec}, {28'h0, sweep_exp[i]});
      edge_update();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 2'(i), 32'hBAD0_0000, 2'(i), 2'(i));
      settle();
      check("sweep_we0", {28'h0, d0_wdec}, 32'h0);
      edge_update();
    end

    drive(1, 1, 2'd3, 32'h7777_7777, 2'd3, 2'd1); settle(); edge_update();
    drive(0, 0, 2'd0, 32'h0, 2'd3, 2'd1);
    settle();
    check("midrst_reg3",  d0_rda, 32'h0);
    check("midrst_reg1",  d0_rdb, 32'h0);
    check("midrst_valid", {28'h0, d0_valid}, 32'h1);
    edge_update();

    // back-to-back writes to one register: last one wins
    drive(0, 1, 2'd1, 32'h0101_0101, 2'd1, 2'd1); settle(); edge_update();
    drive(0, 1, 2'd1, 32'h0202_0202, 2'd2, 2'd1); settle(); edge_update();
    drive(0, 0, 2'd0, 32'h0, 2'd1, 2'd1);
    settle();
    check("last_wins", d1_rda, 32'h0202_0202);
    edge_update();

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 24) == 0), 1'($urandom), 2'($urandom), $urandom,
            2'($urandom), 2'($urandom));
      settle();
      edge_update();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
